// File: rtl/trace_packer.sv
// trace_packer: packs k-lane trace samples (k = 2**NTRACE_I) into WIDTH-bit
// words for a Logger, and streams logged words back out k lanes at a time.
//
// Ports
//   CLK_I, RST_I          clock, synchronous active-high reset
//   MODE_I, NTRACE_I      mode (00 trace, 01 r_stream, 10 w_stream,
//                         11 rw_stream) and lane-count select; latched only
//                         while RST_I=1
//   TRACE_I, TRIGGER_I    parallel sample input, trigger level
//   STORE_O, DATA_O       packed word offered to the Logger
//   STORE_PERM_I          Logger accepts the offered word
//   LOAD_REQUEST_O        request the next word for readout
//   LOAD_GRANT_I, DATA_I  requested word is valid on DATA_I
//   TRACE_O, TRACE_VALID_O streamed-out sample
//   TRG_EVENT_O, EVENT_POS_O first trigger seen and its bit position
//   TRG_DELAYED_I         delayed trigger from the Logger, stops capture
//   OVERFLOW_O            sticky; a completed word was dropped
//
// Capture FSM
//   state    | meaning
//   CAP_FILL | sampling one k-lane sample per cycle into the fill register
//   CAP_STOP | stopped by the delayed trigger; left only by reset
// Readout FSM
//   state    | meaning
//   RD_IDLE  | readout disabled for this mode
//   RD_REQ   | requesting a word from the Logger
//   RD_SHIFT | shifting the loaded word out k lanes per cycle
module trace_packer #(
  parameter int WIDTH       = 32,
  parameter int NTRACE_BITS = 2
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic [1:0]               MODE_I,
  input  logic [NTRACE_BITS-1:0]   NTRACE_I,
  input  logic [7:0]               TRACE_I,
  input  logic                     TRIGGER_I,
  output logic [7:0]               TRACE_O,
  output logic                     TRACE_VALID_O,
  output logic                     STORE_O,
  output logic [WIDTH-1:0]         DATA_O,
  input  logic                     STORE_PERM_I,
  output logic                     LOAD_REQUEST_O,
  input  logic                     LOAD_GRANT_I,
  input  logic [WIDTH-1:0]         DATA_I,
  output logic                     TRG_EVENT_O,
  output logic [$clog2(WIDTH)-1:0] EVENT_POS_O,
  input  logic                     TRG_DELAYED_I,
  output logic                     OVERFLOW_O
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {CAP_FILL, CAP_STOP} cap_e;
  typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_SHIFT} rd_e;

  logic [1:0]             mode_q;
  logic [NTRACE_BITS-1:0] ntrace_q;

  cap_e             cap_q, cap_d;
  rd_e              rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] fill_q, fill_d;
  logic [WIDTH-1:0] sbuf_q, sbuf_d;
  logic             sfull_q, sfull_d;
  logic             ovf_q, ovf_d;
  logic             trg_q, trg_d;
  logic [CW-1:0]    pos_q, pos_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]    rcnt_q, rcnt_d;

  logic [3:0]       k_val;
  logic [7:0]       lane_mask;
  logic [CW:0]      words_per;
  logic [CW-1:0]    cnt_max;
  logic [CW:0]      top_sh;
  logic [WIDTH-1:0] sample_ext;
  logic             trace_mode, cap_en, stop_now, sampling;

  // k lanes per sample; the last count of a word is WIDTH/k - 1.
  assign k_val      = 4'd1 << ntrace_q;
  assign lane_mask  = 8'((9'd1 << k_val) - 9'd1);
  assign words_per  = (CW+1)'(WIDTH) >> ntrace_q;
  assign cnt_max    = words_per[CW-1:0] - 1'b1;
  assign top_sh     = (CW+1)'(WIDTH) - (CW+1)'(k_val);
  assign sample_ext = WIDTH'(TRACE_I & lane_mask) << top_sh;

  assign trace_mode = (mode_q == 2'b00);
  assign cap_en     = (mode_q != 2'b01);
  assign stop_now   = cap_en && trace_mode && (cap_q == CAP_FILL) && TRG_DELAYED_I;
  assign sampling   = cap_en && (cap_q == CAP_FILL) && !stop_now;

  // Configuration is only taken while reset is held.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      mode_q   <= MODE_I;
      ntrace_q <= NTRACE_I;
    end
  end

  always_comb begin
    cap_d   = cap_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    sbuf_d  = sbuf_q;
    sfull_d = sfull_q;
    ovf_d   = ovf_q;
    trg_d   = trg_q;
    pos_d   = pos_q;
    rdata_d = rdata_q;
    rcnt_d  = rcnt_q;

    if (sfull_q && STORE_PERM_I) begin
      sfull_d = 1'b0;
    end

    // Delayed trigger: drop the partial word; a pending store still drains.
    if (stop_now) begin
      cap_d  = CAP_STOP;
      cnt_d  = '0;
      fill_d = '0;
    end

    if (sampling) begin
      fill_d = (fill_q >> k_val) | sample_ext;
      if (trace_mode && TRIGGER_I && !trg_q) begin
        trg_d = 1'b1;
        pos_d = cnt_q << ntrace_q;
      end
      if (cnt_q == cnt_max) begin
        cnt_d = '0;
        // A word completing while the buffer is accepted this same cycle
        // takes the freed slot instead of overflowing.
        if (!sfull_q || STORE_PERM_I) begin
          sbuf_d  = fill_d;
          sfull_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (rd_q)
      RD_REQ: begin
        if (LOAD_GRANT_I) begin
          rdata_d = DATA_I;
          rcnt_d  = '0;
          rd_d    = RD_SHIFT;
        end
      end
      RD_SHIFT: begin
        rdata_d = rdata_q >> k_val;
        if (rcnt_q == cnt_max) begin
          rd_d = RD_REQ;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      cap_q   <= CAP_FILL;
      rd_q    <= MODE_I[0] ? RD_REQ : RD_IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
      sbuf_q  <= '0;
      sfull_q <= 1'b0;
      ovf_q   <= 1'b0;
      trg_q   <= 1'b0;
      pos_q   <= '0;
      rdata_q <= '0;
      rcnt_q  <= '0;
    end else begin
      cap_q   <= cap_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      sbuf_q  <= sbuf_d;
      sfull_q <= sfull_d;
      ovf_q   <= ovf_d;
      trg_q   <= trg_d;
      pos_q   <= pos_d;
      rdata_q <= rdata_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign TRACE_VALID_O  = (rd_q == RD_SHIFT);
  assign TRACE_O        = (rd_q == RD_SHIFT) ? (rdata_q[7:0] & lane_mask) : 8'h00;
  // Request is held low while reset is asserted so every output reads 0
  // during reset; it rises in the first cycle after release.
  assign LOAD_REQUEST_O = (rd_q == RD_REQ) && !RST_I;
  assign STORE_O        = sfull_q;
  assign DATA_O         = sbuf_q;
  assign TRG_EVENT_O    = trg_q;
  assign EVENT_POS_O    = pos_q;
  assign OVERFLOW_O     = ovf_q;

endmodule

// File: tb/tb_trace_packer.sv
module tb_trace_packer;
  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [1:0]        ntrace = 2'd0;
  logic [7:0]        tr = 8'h00;
  logic              trig = 1'b0;
  logic              perm = 1'b0;
  logic              grant = 1'b0;
  logic [WIDTH-1:0]  din = '0;
  logic              delayed = 1'b0;
  logic [7:0]        trace_o;
  logic              valid_o, store_o, req_o, trg_o, ovf_o;
  logic [WIDTH-1:0]  data_o;
  logic [4:0]        pos_o;

  int n_tests = 0;
  int n_fail  = 0;

  trace_packer #(.WIDTH(WIDTH), .NTRACE_BITS(2)) dut (
    .CLK_I(clk), .RST_I(rst), .MODE_I(mode), .NTRACE_I(ntrace),
    .TRACE_I(tr), .TRIGGER_I(trig), .TRACE_O(trace_o), .TRACE_VALID_O(valid_o),
    .STORE_O(store_o), .DATA_O(data_o), .STORE_PERM_I(perm),
    .LOAD_REQUEST_O(req_o), .LOAD_GRANT_I(grant), .DATA_I(din),
    .TRG_EVENT_O(trg_o), .EVENT_POS_O(pos_o), .TRG_DELAYED_I(delayed),
    .OVERFLOW_O(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [1:0] n);
    rst = 1'b1; mode = m; ntrace = n;
    tr = 8'h00; trig = 1'b0; perm = 1'b0; grant = 1'b0; delayed = 1'b0; din = '0;
    tick();
    rst = 1'b0;
  endtask

  // Reference model: counts samples per word and ORs each sample into
  // its lane slot; tracks one pending store and the readout word.
  logic [1:0]       m_mode;
  int               m_k, m_samples, m_rd_left;
  logic [WIDTH-1:0] m_word, m_pend_word, m_rd_word;
  logic             m_pend, m_ovf, m_trg, m_stopped;
  int               m_pos;

  task automatic model_step();
    logic [WIDTH-1:0] ext, done_word;
    logic complete;
    int wpw;
    if (rst) begin
      m_mode = mode; m_k = 1 << ntrace;
      m_samples = 0; m_word = '0; m_pend = 1'b0; m_pend_word = '0;
      m_ovf = 1'b0; m_trg = 1'b0; m_pos = 0; m_stopped = 1'b0;
      m_rd_left = 0; m_rd_word = '0;
      return;
    end
    wpw = WIDTH / m_k;
    complete = 1'b0;
    done_word = '0;
    if (m_mode != 2'b01 && !m_stopped) begin
      if (m_mode == 2'b00 && delayed) begin
        m_stopped = 1'b1; m_samples = 0; m_word = '0;
      end else begin
        if (m_mode == 2'b00 && trig && !m_trg) begin
          m_trg = 1'b1; m_pos = m_samples * m_k;
        end
        ext = WIDTH'(tr & 8'((1 << m_k) - 1));
        m_word = m_word | (ext << (m_samples * m_k));
        m_samples++;
        if (m_samples == wpw) begin
          complete = 1'b1; done_word = m_word; m_samples = 0; m_word = '0;
        end
      end
    end
    if (complete) begin
      if (m_pend && !perm) m_ovf = 1'b1;
      else begin m_pend = 1'b1; m_pend_word = done_word; end
    end else if (m_pend && perm) begin
      m_pend = 1'b0;
    end
    if (m_mode[0]) begin
      if (m_rd_left == 0) begin
        if (grant) begin m_rd_word = din; m_rd_left = wpw; end
      end else begin
        m_rd_word = m_rd_word >> m_k; m_rd_left--;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'b01; ntrace = 2'd3; tr = 8'hFF; trig = 1'b1;
    perm = 1'b1; grant = 1'b1; din = 32'h1234_5678; delayed = 1'b0;
    tick();
    n_tests++;
    if ({store_o, valid_o, req_o, trg_o, ovf_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 00000", {store_o, valid_o, req_o, trg_o, ovf_o});
    end
    n_tests++;
    if (trace_o !== 8'h00 || pos_o !== 5'd0) begin
      n_fail++; $display("FAIL reset_trace_pos got %h/%0d want 00/0", trace_o, pos_o);
    end
    rst = 1'b0; grant = 1'b0; #1;
    n_tests++;
    if (req_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_rstream_req got %b want 1", req_o);
    end
  endtask

  task automatic test_pack_trigger();
    do_reset(2'b00, 2'd2);
    perm = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tr = 8'(i); trig = (i == 3 || i == 5);
      tick();
      n_tests++;
      if (store_o !== (i == 8)) begin
        n_fail++; $display("FAIL pack_store_timing sample %0d got %b want %b", i, store_o, (i == 8));
      end
    end
    tr = 8'h00; trig = 1'b0;
    n_tests++;
    if (data_o !== 32'h8765_4321) begin
      n_fail++; $display("FAIL pack_data got %h want 87654321", data_o);
    end
    n_tests++;
    if (trg_o !== 1'b1 || pos_o !== 5'd8) begin
      n_fail++; $display("FAIL trigger_pos got %b/%0d want 1/8", trg_o, pos_o);
    end
    tick();
    n_tests++;
    if (store_o !== 1'b0) begin
      n_fail++; $display("FAIL pack_store_drop got %b want 0", store_o);
    end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] w1;
    logic [3:0] s;
    do_reset(2'b10, 2'd2);
    w1 = '0;
    for (int i = 0; i < 16; i++) begin
      s = 4'($urandom_range(0, 15));
      if (i < 8) w1 = w1 | (WIDTH'(s) << (4 * i));
      tr = {4'hA, s};
      tick();
    end
    n_tests++;
    if (store_o !== 1'b1 || data_o !== w1) begin
      n_fail++; $display("FAIL ovf_hold got %b/%h want 1/%h", store_o, data_o, w1);
    end
    n_tests++;
    if (ovf_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flag got %b want 1", ovf_o);
    end
    perm = 1'b1;
    tick();
    perm = 1'b0;
    n_tests++;
    if (store_o !== 1'b0 || ovf_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_after_accept got %b/%b want 0/1", store_o, ovf_o);
    end
  endtask

  task automatic test_readout();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h0F; exp_b[2] = 8'hC3; exp_b[3] = 8'hA5;
    do_reset(2'b01, 2'd3);
    #1;
    n_tests++;
    if (req_o !== 1'b1 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rd_req_initial got %b/%b want 1/0", req_o, valid_o);
    end
    grant = 1'b1; din = 32'hA5C3_0F11;
    tick();
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (valid_o !== 1'b1 || req_o !== 1'b0 || trace_o !== exp_b[j]) begin
        n_fail++; $display("FAIL rd_lane %0d got v%b r%b %h want v1 r0 %h", j, valid_o, req_o, trace_o, exp_b[j]);
      end
      grant = (j < 3); din = 32'hDEAD_BEEF;
      tick();
    end
    n_tests++;
    if (valid_o !== 1'b0 || req_o !== 1'b1 || trace_o !== 8'h00) begin
      n_fail++; $display("FAIL rd_back_to_req got v%b r%b %h want v0 r1 00", valid_o, req_o, trace_o);
    end
  endtask

  task automatic test_delayed();
    int stores;
    do_reset(2'b00, 2'd2);
    perm = 1'b1; stores = 0;
    for (int i = 0; i < 3; i++) begin tr = 8'(i + 1); tick(); end
    delayed = 1'b1; tick(); delayed = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tr = 8'($urandom); trig = 1'b1;
      tick();
      if (store_o) stores++;
    end
    trig = 1'b0;
    n_tests++;
    if (stores != 0 || trg_o !== 1'b0) begin
      n_fail++; $display("FAIL delayed_stop stores %0d trg %b want 0 0", stores, trg_o);
    end
  endtask

  task automatic test_reset_midword();
    int stores;
    logic [WIDTH-1:0] got;
    do_reset(2'b00, 2'd2);
    perm = 1'b1; stores = 0; got = '0;
    for (int i = 0; i < 5; i++) begin tr = 8'h0F; tick(); end
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tr = (i <= 8) ? 8'(i) : 8'h00;
      tick();
      if (store_o) begin stores++; got = data_o; end
    end
    n_tests++;
    if (stores != 1 || got !== 32'h8765_4321) begin
      n_fail++; $display("FAIL reset_midword stores %0d data %h want 1 87654321", stores, got);
    end
  endtask

  task automatic test_random();
    logic e_valid, e_req;
    logic [7:0] e_trace;
    int errs;
    errs = 0;
    for (int c = 0; c < 4000; c++) begin
      rst     = (c == 0) || ($urandom_range(0, 60) == 0);
      mode    = 2'($urandom);
      ntrace  = 2'($urandom);
      tr      = 8'($urandom);
      trig    = ($urandom_range(0, 7) == 0);
      perm    = ($urandom_range(0, 2) != 0);
      grant   = $urandom_range(0, 1) == 1;
      din     = WIDTH'($urandom);
      delayed = ($urandom_range(0, 150) == 0);
      model_step();
      tick();
      e_valid = m_mode[0] && (m_rd_left > 0);
      e_trace = e_valid ? (m_rd_word[7:0] & 8'((1 << m_k) - 1)) : 8'h00;
      e_req   = m_mode[0] && (m_rd_left == 0) && !rst;
      n_tests++;
      if (store_o !== m_pend || (m_pend && data_o !== m_pend_word)) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rnd_store cyc %0d got %b/%h want %b/%h", c, store_o, data_o, m_pend, m_pend_word);
      end
      n_tests++;
      if (ovf_o !== m_ovf || trg_o !== m_trg || pos_o !== 5'(m_pos)) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rnd_flags cyc %0d got o%b t%b p%0d want o%b t%b p%0d", c, ovf_o, trg_o, pos_o, m_ovf, m_trg, m_pos);
      end
      n_tests++;
      if (valid_o !== e_valid || trace_o !== e_trace || req_o !== e_req) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rnd_read cyc %0d got v%b %h r%b want v%b %h r%b", c, valid_o, trace_o, req_o, e_valid, e_trace, e_req);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pack_trigger();
    test_overflow();
    test_readout();
    test_delayed();
    test_reset_midword();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
